pipelined_alu: RTL and testbench

- Parametrised, pipelined integer ALU; successor to the 4-op combinational ALU in the execute stage of the RISC-V core.
- Accepts one operation per cycle under a valid/ready handshake.
- Supports the RV32I ALU op set plus status flags, with configurable latency.
- Carries an opaque tag (e.g. destination register) alongside each result for writeback.

---
 rtl/alu_pkg.sv | 29 ++
 rtl/pipelined_alu_if.sv | 41 ++++
 rtl/alu_pipe_stage.sv | 31 +++
 rtl/pipelined_alu.sv | 104 ++++++++++
 tb/tb_pipelined_alu.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Purpose: shared opcode encodings and flag bundle for the pipelined ALU.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_pkg;

  localparam int FUNC_W = 4;

  localparam logic [FUNC_W-1:0] ALU_ADD    = 4'b0000;
  localparam logic [FUNC_W-1:0] ALU_SUB    = 4'b0001;
  localparam logic [FUNC_W-1:0] ALU_AND    = 4'b0010;
  localparam logic [FUNC_W-1:0] ALU_OR     = 4'b0011;
  localparam logic [FUNC_W-1:0] ALU_XOR    = 4'b0100;
  localparam logic [FUNC_W-1:0] ALU_SLL    = 4'b0101;
  localparam logic [FUNC_W-1:0] ALU_SRL    = 4'b0110;
  localparam logic [FUNC_W-1:0] ALU_SRA    = 4'b0111;
  localparam logic [FUNC_W-1:0] ALU_SLT    = 4'b1000;
  localparam logic [FUNC_W-1:0] ALU_SLTU   = 4'b1001;
  localparam logic [FUNC_W-1:0] ALU_PASS_B = 4'b1010;

  // Status part of the stage payload. The full payload struct lives in the
  // top because its result/tag widths depend on module parameters.
  typedef struct packed {
    logic zero;
    logic carry;
    logic ovf;
    logic illegal;
  } alu_flags_t;

endpackage

// File: rtl/pipelined_alu_if.sv
// Purpose: request/response bundle between an issuing stage and the ALU.
// Latency: n/a (wires only).
// Backpressure: in_ready / out_ready carry the valid-ready handshake.
// Ports: request side in_valid/in_ready/func/operand_1/operand_2/in_tag;
//        response side out_valid/out_ready/result/out_tag/flags/illegal_op.
interface pipelined_alu_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
);
  import alu_pkg::*;

  logic                  in_valid;
  logic                  in_ready;
  logic [FUNC_W-1:0]     func;
  logic [WIDTH-1:0]      operand_1;
  logic [WIDTH-1:0]      operand_2;
  logic [TAG_W-1:0]      in_tag;
  logic                  out_valid;
  logic                  out_ready;
  logic [WIDTH-1:0]      result;
  logic [TAG_W-1:0]      out_tag;
  logic                  flag_zero;
  logic                  flag_carry;
  logic                  flag_ovf;
  logic                  illegal_op;

  // Issuer / consumer side.
  modport master (
    output in_valid, func, operand_1, operand_2, in_tag, out_ready,
    input  in_ready, out_valid, result, out_tag,
           flag_zero, flag_carry, flag_ovf, illegal_op
  );

  // ALU side.
  modport slave (
    input  in_valid, func, operand_1, operand_2, in_tag, out_ready,
    output in_ready, out_valid, result, out_tag,
           flag_zero, flag_carry, flag_ovf, illegal_op
  );

endinterface

// File: rtl/alu_pipe_stage.sv
// Purpose: one valid/ready register slice carrying an opaque payload.
// Latency: 1 cycle.
// Backpressure: up_rdy = empty or draining this cycle; no skid buffer.
// Ports: clk, rst_n, upstream up_vld/up_rdy/up_dat, downstream dn_vld/dn_rdy/dn_dat.
module alu_pipe_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         up_vld,
  output logic         up_rdy,
  input  logic [W-1:0] up_dat,
  output logic         dn_vld,
  input  logic         dn_rdy,
  output logic [W-1:0] dn_dat
);

  assign up_rdy = !dn_vld || dn_rdy;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dn_vld <= 1'b0;
      dn_dat <= '0;
    end else if (up_rdy) begin
      dn_vld <= up_vld;
      // Payload only moves with a real transfer, so bubbles leave data untouched.
      if (up_vld) dn_dat <= up_dat;
    end
  end

endmodule

// File: rtl/pipelined_alu.sv
// Purpose: RV32I-style integer ALU with flags and pass-through tag, pipelined.
// Latency: STAGES cycles from accepted request to out_valid.
// Backpressure: in_ready is combinational from out_ready through every slice.
// Ports: clk, rst_n (sync, active-low), bus (pipelined_alu_if.slave).
module pipelined_alu
  import alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int TAG_W  = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pipelined_alu_if.slave        bus
);

  localparam int SHW = $clog2(WIDTH);

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic [TAG_W-1:0] tag;
    alu_flags_t       flags;
  } payload_t;

  localparam int PW = $bits(payload_t);

  function automatic payload_t alu_compute(
    input logic [FUNC_W-1:0] f,
    input logic [WIDTH-1:0]  a,
    input logic [WIDTH-1:0]  b,
    input logic [TAG_W-1:0]  tag
  );
    payload_t       p;
    logic [WIDTH:0] wide;
    logic [SHW-1:0] sh;
    p      = '0;
    p.tag  = tag;
    wide   = '0;
    sh     = b[SHW-1:0];
    case (f)
      ALU_ADD: begin
        wide          = {1'b0, a} + {1'b0, b};
        p.result      = wide[WIDTH-1:0];
        p.flags.carry = wide[WIDTH];
        p.flags.ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (wide[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_SUB: begin
        // a + ~b + 1: bit WIDTH is the no-borrow indication.
        wide          = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
        p.result      = wide[WIDTH-1:0];
        p.flags.carry = wide[WIDTH];
        p.flags.ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (wide[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_AND:    p.result = a & b;
      ALU_OR:     p.result = a | b;
      ALU_XOR:    p.result = a ^ b;
      ALU_SLL:    p.result = a << sh;
      ALU_SRL:    p.result = a >> sh;
      ALU_SRA:    p.result = $unsigned($signed(a) >>> sh);
      ALU_SLT:    p.result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU:   p.result = {{(WIDTH-1){1'b0}}, (a < b)};
      ALU_PASS_B: p.result = b;
      default:    p.flags.illegal = 1'b1;
    endcase
    // Illegal ops report all flags clear, including zero.
    p.flags.zero = !p.flags.illegal && (p.result == '0);
    return p;
  endfunction

  // Index k is the input of slice k; index STAGES is the output port.
  logic          vld [STAGES+1];
  logic          rdy [STAGES+1];
  logic [PW-1:0] dat [STAGES+1];

  assign vld[0]      = bus.in_valid;
  assign dat[0]      = alu_compute(bus.func, bus.operand_1, bus.operand_2, bus.in_tag);
  assign bus.in_ready = rdy[0];
  assign rdy[STAGES] = bus.out_ready;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    alu_pipe_stage #(.W(PW)) u_stage (
      .clk    (clk),
      .rst_n  (rst_n),
      .up_vld (vld[k]),
      .up_rdy (rdy[k]),
      .up_dat (dat[k]),
      .dn_vld (vld[k+1]),
      .dn_rdy (rdy[k+1]),
      .dn_dat (dat[k+1])
    );
  end

  payload_t out_p;
  assign out_p = payload_t'(dat[STAGES]);

  assign bus.out_valid  = vld[STAGES];
  assign bus.result     = out_p.result;
  assign bus.out_tag    = out_p.tag;
  assign bus.flag_zero  = out_p.flags.zero;
  assign bus.flag_carry = out_p.flags.carry;
  assign bus.flag_ovf   = out_p.flags.ovf;
  assign bus.illegal_op = out_p.flags.illegal;

endmodule

// File: tb/tb_pipelined_alu.sv
module tb_pipelined_alu;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pipelined_alu_if #(.WIDTH(32), .TAG_W(5)) bus ();

  pipelined_alu #(.WIDTH(32), .STAGES(2), .TAG_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic [3:0]  func;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  tag;
    logic [31:0] res;
    logic        z, c, o, ill;
  } vec_t;

  vec_t vecs [18];

  function automatic vec_t mkv(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b,
                               input logic [4:0] tag, input logic [31:0] res,
                               input logic z, input logic c, input logic o, input logic ill);
    vec_t v;
    v.func = f; v.a = a; v.b = b; v.tag = tag; v.res = res;
    v.z = z; v.c = c; v.o = o; v.ill = ill;
    return v;
  endfunction

  // Observed output bundle: {pad, valid, result, tag, zero, carry, ovf, illegal}.
  function automatic logic [63:0] obs();
    return {22'b0, bus.out_valid, bus.result, bus.out_tag,
            bus.flag_zero, bus.flag_carry, bus.flag_ovf, bus.illegal_op};
  endfunction

  function automatic logic [63:0] expo(input logic [31:0] res, input logic [4:0] tag,
                                       input logic [3:0] zcoi);
    return {22'b0, 1'b1, res, tag, zcoi};
  endfunction

  // Independent reference: 64-bit arithmetic, range check for overflow.
  function automatic logic [35:0] model(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] res;
    logic        c, o, ill;
    logic [63:0] u;
    longint      sa, sb, s;
    res = '0; c = 1'b0; o = 1'b0; ill = 1'b0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (f)
      4'd0: begin
        u = {32'b0, a} + {32'b0, b};
        res = u[31:0]; c = u[32];
        s = sa + sb; o = (s != longint'(int'(s)));
      end
      4'd1: begin
        res = a - b; c = (a >= b);
        s = sa - sb; o = (s != longint'(int'(s)));
      end
      4'd2:  res = a & b;
      4'd3:  res = a | b;
      4'd4:  res = a ^ b;
      4'd5:  res = a << b[4:0];
      4'd6:  res = a >> b[4:0];
      4'd7:  res = 32'($signed(a) >>> b[4:0]);
      4'd8:  res = (sa < sb) ? 32'd1 : 32'd0;
      4'd9:  res = (a < b) ? 32'd1 : 32'd0;
      4'd10: res = b;
      default: ill = 1'b1;
    endcase
    return {res, (!ill && res == 32'd0), c, o, ill};
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    n_chk++;
    n_err++;
    $display("FAIL %s: got unexpected output expected none", nm);
  endtask

  task automatic drive(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag);
    bus.in_valid  = 1'b1;
    bus.func      = f;
    bus.operand_1 = a;
    bus.operand_2 = b;
    bus.in_tag    = tag;
  endtask

  // Single op with exact-latency check: not valid after 1 edge, valid after 2.
  task automatic apply_vec(input vec_t v, input int idx);
    @(negedge clk);
    bus.out_ready = 1'b1;
    drive(v.func, v.a, v.b, v.tag);
    #1 chk($sformatf("vec%0d_in_ready", idx), 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1 chk($sformatf("vec%0d_early", idx), 64'(bus.out_valid), 64'd0);
    @(negedge clk);
    #1 chk($sformatf("vec%0d_out", idx), obs(), expo(v.res, v.tag, {v.z, v.c, v.o, v.ill}));
  endtask

  logic [63:0] expq [$];
  logic [63:0] held;
  logic [35:0] m;
  logic [31:0] ra, rb;
  logic [3:0]  rf;
  int sent, got, gaps, stalls, nt, acc_at_stall, seen;

  function automatic logic [31:0] pick();
    logic [31:0] sp [4];
    sp[0] = 32'h0; sp[1] = 32'hFFFF_FFFF; sp[2] = 32'h8000_0000; sp[3] = 32'h7FFF_FFFF;
    if ($urandom_range(0, 3) == 0) return sp[$urandom_range(0, 3)];
    return $urandom;
  endfunction

  initial begin
    vecs[0]  = mkv(4'h0, 32'h7FFF_FFFF, 32'h1,         5'd1,  32'h8000_0000, 0, 0, 1, 0);
    vecs[1]  = mkv(4'h1, 32'h5,         32'h5,         5'd2,  32'h0,         1, 1, 0, 0);
    vecs[2]  = mkv(4'h7, 32'h8000_0000, 32'h21,        5'd3,  32'hC000_0000, 0, 0, 0, 0);
    vecs[3]  = mkv(4'h8, 32'hFFFF_FFFF, 32'h1,         5'd4,  32'h1,         0, 0, 0, 0);
    vecs[4]  = mkv(4'h9, 32'hFFFF_FFFF, 32'h1,         5'd5,  32'h0,         1, 0, 0, 0);
    vecs[5]  = mkv(4'hF, 32'h1234,      32'h5,         5'd6,  32'h0,         0, 0, 0, 1);
    vecs[6]  = mkv(4'h0, 32'hFFFF_FFFF, 32'h1,         5'd7,  32'h0,         1, 1, 0, 0);
    vecs[7]  = mkv(4'h1, 32'h3,         32'h5,         5'd8,  32'hFFFF_FFFE, 0, 0, 0, 0);
    vecs[8]  = mkv(4'h1, 32'h8000_0000, 32'h1,         5'd9,  32'h7FFF_FFFF, 0, 1, 1, 0);
    vecs[9]  = mkv(4'h2, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd10, 32'hF000_F000, 0, 0, 0, 0);
    vecs[10] = mkv(4'h3, 32'h0F00_0000, 32'h0000_00F0, 5'd11, 32'h0F00_00F0, 0, 0, 0, 0);
    vecs[11] = mkv(4'h4, 32'hAAAA_AAAA, 32'hFFFF_FFFF, 5'd12, 32'h5555_5555, 0, 0, 0, 0);
    vecs[12] = mkv(4'h5, 32'h1,         32'h3F,        5'd13, 32'h8000_0000, 0, 0, 0, 0);
    vecs[13] = mkv(4'h6, 32'h8000_0000, 32'h4,         5'd14, 32'h0800_0000, 0, 0, 0, 0);
    vecs[14] = mkv(4'hA, 32'h1,         32'hDEAD_BEEF, 5'd15, 32'hDEAD_BEEF, 0, 0, 0, 0);
    vecs[15] = mkv(4'hB, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd16, 32'h0,         0, 0, 0, 1);
    vecs[16] = mkv(4'h8, 32'h1,         32'hFFFF_FFFF, 5'd17, 32'h0,         1, 0, 0, 0);
    vecs[17] = mkv(4'h9, 32'h1,         32'hFFFF_FFFF, 5'd31, 32'h1,         0, 0, 0, 0);

    // Reset held 3 cycles with a request pending.
    rst_n = 1'b0;
    bus.out_ready = 1'b1;
    drive(4'h0, 32'h1, 32'h2, 5'd3);
    repeat (3) @(negedge clk);
    #1 chk("reset_outputs", obs(), 64'd0);
    rst_n = 1'b1;
    bus.in_valid = 1'b0;
    #1 chk("reset_in_ready", 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    #1 chk("reset_no_output", 64'(bus.out_valid), 64'd0);

    for (int i = 0; i < 18; i++) apply_vec(vecs[i], i);

    // Backpressure: tags 1..6 back to back, consumer stalls in cycles 3..6.
    nt = 1; got = 0; acc_at_stall = 0; held = '0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge clk);
      bus.out_ready = !(cyc >= 3 && cyc <= 6);
      if (nt <= 6) drive(4'h0, 32'(nt), 32'd100, 5'(nt));
      else bus.in_valid = 1'b0;
      #1;
      if (cyc == 3) begin
        acc_at_stall = nt - 1;
        held = obs();
      end
      if (cyc >= 3 && cyc <= 6) chk("bp_in_ready_low", 64'(bus.in_ready), 64'd0);
      if (cyc > 3 && cyc <= 6) chk("bp_hold", obs(), held);
      if (bus.in_valid && bus.in_ready) begin
        expq.push_back(expo(32'(nt) + 32'd100, 5'(nt), 4'b0000));
        nt++;
      end
      if (bus.out_valid && bus.out_ready) begin
        if (expq.size() == 0) fail_now("bp_extra");
        else chk("bp_out", obs(), expq.pop_front());
        got++;
      end
    end
    chk("bp_accepts_before_stall", 64'(acc_at_stall), 64'd3);
    chk("bp_held_word", held, expo(32'd102, 5'd2, 4'b0000));
    chk("bp_count", 64'(got), 64'd6);

    // Full throughput: 100 random ops, consumer always ready.
    expq.delete();
    sent = 0; got = 0; gaps = 0; stalls = 0;
    for (int cyc = 0; cyc < 105; cyc++) begin
      @(negedge clk);
      bus.out_ready = 1'b1;
      if (sent < 100) begin
        rf = 4'($urandom_range(0, 15));
        ra = pick();
        rb = pick();
        drive(rf, ra, rb, 5'(sent));
      end else begin
        bus.in_valid = 1'b0;
      end
      #1;
      if (bus.in_valid) begin
        if (bus.in_ready) begin
          m = model(rf, ra, rb);
          expq.push_back(expo(m[35:4], 5'(sent), m[3:0]));
          sent++;
        end else begin
          stalls++;
        end
      end
      if (cyc >= 2 && cyc <= 101 && !bus.out_valid) gaps++;
      if (bus.out_valid) begin
        if (expq.size() == 0) fail_now("thru_extra");
        else chk($sformatf("thru_out%0d", got), obs(), expq.pop_front());
        got++;
      end
    end
    chk("thru_count", 64'(got), 64'd100);
    chk("thru_in_stalls", 64'(stalls), 64'd0);
    chk("thru_gaps", 64'(gaps), 64'd0);

    // Reset with two ops in flight: both dropped.
    @(negedge clk);
    bus.out_ready = 1'b0;
    drive(4'h0, 32'd10, 32'd20, 5'd9);
    @(negedge clk);
    drive(4'h1, 32'd50, 32'd8, 5'd10);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1 chk("mid_inflight_valid", 64'(bus.out_valid), 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    #1 chk("mid_reset_outputs", obs(), 64'd0);
    chk("mid_reset_in_ready", 64'(bus.in_ready), 64'd1);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      #1 if (bus.out_valid) seen++;
    end
    chk("mid_dropped", 64'(seen), 64'd0);
    apply_vec(mkv(4'h0, 32'd40, 32'd2, 5'd21, 32'd42, 0, 0, 0, 0), 100);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
